// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction-fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

   localparam int PC_W    = 16;
   localparam int INSTR_W = 16;

   localparam logic [PC_W-1:0] c_DEFAULT_RESET_PC = 16'h0000;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_REQ  = 2'd1,
      FS_WAIT = 2'd2,
      FS_HOLD = 2'd3
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_pc_reg.sv
// ============================================================================
// Module   : fetch_pc_reg
// Purpose  : Program counter; branch load has priority over increment.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = c_DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_load,
   input  logic [PC_W-1:0] i_target,
   input  logic            i_inc,
   output logic [PC_W-1:0] o_pc
);

   localparam logic [PC_W-1:0] c_PC_ONE = 1;

   logic [PC_W-1:0] r_pc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc <= RESET_PC;
      end else if (i_load) begin
         r_pc <= i_target;
      end else if (i_inc) begin
         r_pc <= r_pc + c_PC_ONE;
      end
   end

   assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : IF stage: PC, single-outstanding imem request, IF/ID register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = c_DEFAULT_RESET_PC
) (
   input  logic               clk_pi,
   input  logic               reset_n_pi,
   input  logic               is_branch_taken_pi,
   input  logic [PC_W-1:0]    branch_target_pi,
   output logic               imem_req_po,
   output logic [PC_W-1:0]    imem_addr_po,
   input  logic               imem_gnt_pi,
   input  logic               imem_rvalid_pi,
   input  logic [INSTR_W-1:0] imem_rdata_pi,
   output logic               if_valid_po,
   output logic [INSTR_W-1:0] if_instr_po,
   output logic [PC_W-1:0]    if_pc_po,
   input  logic               id_ready_pi,
   output logic               squash_po
);

   fetch_state_t         r_state;
   logic                 r_drop;
   logic                 r_if_valid;
   logic [INSTR_W-1:0]   r_if_instr;
   logic [PC_W-1:0]      r_if_pc;
   logic [PC_W-1:0]      w_pc;
   logic                 w_pc_inc;

   // Advance only when a live (not dropped, not redirected) word is captured
   assign w_pc_inc = (r_state == FS_WAIT) & imem_rvalid_pi & ~r_drop
                   & ~is_branch_taken_pi;

   fetch_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk      (clk_pi),
      .rst_n    (reset_n_pi),
      .i_load   (is_branch_taken_pi),
      .i_target (branch_target_pi),
      .i_inc    (w_pc_inc),
      .o_pc     (w_pc)
   );

   always_ff @(posedge clk_pi) begin
      if (!reset_n_pi) begin
         r_state    <= FS_IDLE;
         r_drop     <= 1'b0;
         r_if_valid <= 1'b0;
         r_if_instr <= '0;
         r_if_pc    <= '0;
      end else if (is_branch_taken_pi) begin
         r_if_valid <= 1'b0;
         case (r_state)
            FS_REQ: begin
               if (imem_gnt_pi) begin
                  r_state <= FS_WAIT;
                  r_drop  <= 1'b1;
               end
            end
            FS_WAIT: begin
               if (imem_rvalid_pi) begin
                  r_state <= FS_REQ;
                  r_drop  <= 1'b0;
               end else begin
                  r_drop  <= 1'b1;
               end
            end
            default: r_state <= FS_REQ;
         endcase
      end else begin
         case (r_state)
            FS_IDLE: r_state <= FS_REQ;
            FS_REQ: begin
               if (imem_gnt_pi) r_state <= FS_WAIT;
            end
            FS_WAIT: begin
               if (imem_rvalid_pi) begin
                  if (r_drop) begin
                     r_drop  <= 1'b0;
                     r_state <= FS_REQ;
                  end else begin
                     r_if_valid <= 1'b1;
                     r_if_instr <= imem_rdata_pi;
                     r_if_pc    <= w_pc;
                     r_state    <= FS_HOLD;
                  end
               end
            end
            FS_HOLD: begin
               if (id_ready_pi) begin
                  r_if_valid <= 1'b0;
                  r_state    <= FS_REQ;
               end
            end
            default: r_state <= FS_IDLE;
         endcase
      end
   end

   assign imem_req_po  = (r_state == FS_REQ);
   assign imem_addr_po = w_pc;
   assign if_valid_po  = r_if_valid;
   assign if_instr_po  = r_if_instr;
   assign if_pc_po     = r_if_pc;
   assign squash_po    = is_branch_taken_pi & r_if_valid;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed bench for fetch_unit (RESET_PC=0 and a wrap instance).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

   logic        clk;
   logic        reset_n;
   logic        branch;
   logic [15:0] target;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic        id_ready;
   logic        squash;

   logic        wp_branch;
   logic [15:0] wp_target;
   logic        wp_req;
   logic [15:0] wp_addr;
   logic        wp_gnt;
   logic        wp_rvalid;
   logic [15:0] wp_rdata;
   logic        wp_valid;
   logic [15:0] wp_instr;
   logic [15:0] wp_pc;
   logic        wp_ready;
   logic        wp_squash;

   int n_vec = 0;
   int n_err = 0;

   fetch_unit #(.RESET_PC(16'h0000)) dut (
      .clk_pi             (clk),
      .reset_n_pi         (reset_n),
      .is_branch_taken_pi (branch),
      .branch_target_pi   (target),
      .imem_req_po        (imem_req),
      .imem_addr_po       (imem_addr),
      .imem_gnt_pi        (imem_gnt),
      .imem_rvalid_pi     (imem_rvalid),
      .imem_rdata_pi      (imem_rdata),
      .if_valid_po        (if_valid),
      .if_instr_po        (if_instr),
      .if_pc_po           (if_pc),
      .id_ready_pi        (id_ready),
      .squash_po          (squash)
   );

   fetch_unit #(.RESET_PC(16'hFFFF)) dut_wrap (
      .clk_pi             (clk),
      .reset_n_pi         (reset_n),
      .is_branch_taken_pi (wp_branch),
      .branch_target_pi   (wp_target),
      .imem_req_po        (wp_req),
      .imem_addr_po       (wp_addr),
      .imem_gnt_pi        (wp_gnt),
      .imem_rvalid_pi     (wp_rvalid),
      .imem_rdata_pi      (wp_rdata),
      .if_valid_po        (wp_valid),
      .if_instr_po        (wp_instr),
      .if_pc_po           (wp_pc),
      .id_ready_pi        (wp_ready),
      .squash_po          (wp_squash)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Entered in REQ; leaves the DUT in HOLD with id_ready set to rdy.
   task automatic fetch_one(input logic [15:0] a, input logic [15:0] d, input logic rdy);
      chk("req_req", {15'b0, imem_req}, 16'd1);
      chk("req_addr", imem_addr, a);
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      chk("wait_req", {15'b0, imem_req}, 16'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = d;
      step();
      imem_rvalid = 1'b0;
      chk("hold_valid", {15'b0, if_valid}, 16'd1);
      chk("hold_instr", if_instr, d);
      chk("hold_pc", if_pc, a);
      id_ready = rdy;
   endtask

   initial begin
      reset_n = 1'b0; branch = 1'b0; target = '0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
      wp_branch = 1'b0; wp_target = '0; wp_gnt = 1'b0; wp_rvalid = 1'b0;
      wp_rdata = '0; wp_ready = 1'b0;
      @(negedge clk);
      step();
      step();

      // Reset state
      chk("rst_req", {15'b0, imem_req}, 16'd0);
      chk("rst_addr", imem_addr, 16'h0000);
      chk("rst_valid", {15'b0, if_valid}, 16'd0);
      chk("rst_instr", if_instr, 16'h0000);
      chk("rst_pc", if_pc, 16'h0000);
      chk("rst_squash", {15'b0, squash}, 16'd0);
      chk("rst_wp_addr", wp_addr, 16'hFFFF);
      chk("rst_wp_pc", wp_pc, 16'h0000);

      // Sequential fetch, 3-cycle cadence
      reset_n = 1'b1;
      chk("idle_req", {15'b0, imem_req}, 16'd0);
      step();
      fetch_one(16'h0000, 16'h1000, 1'b1);
      step();
      chk("seq_gap0", {15'b0, if_valid}, 16'd0);
      fetch_one(16'h0001, 16'h1111, 1'b1);
      step();
      chk("seq_gap1", {15'b0, if_valid}, 16'd0);
      fetch_one(16'h0002, 16'h2222, 1'b1);
      step();

      // Backpressure in HOLD
      fetch_one(16'h0003, 16'h3333, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_valid", {15'b0, if_valid}, 16'd1);
         chk("bp_instr", if_instr, 16'h3333);
         chk("bp_pc", if_pc, 16'h0003);
         chk("bp_req", {15'b0, imem_req}, 16'd0);
      end
      id_ready = 1'b1;
      step();
      fetch_one(16'h0004, 16'h4444, 1'b1);
      step();

      // Branch while 0x0005 is outstanding
      chk("bw_addr", imem_addr, 16'h0005);
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      branch = 1'b1; target = 16'h0040;
      step();
      branch = 1'b0;
      chk("bw_req", {15'b0, imem_req}, 16'd0);
      imem_rvalid = 1'b1; imem_rdata = 16'hDEAD;
      step();
      imem_rvalid = 1'b0;
      chk("bw_drop_valid", {15'b0, if_valid}, 16'd0);
      fetch_one(16'h0040, 16'h4040, 1'b0);

      // Branch in HOLD with id_ready in the same cycle
      branch = 1'b1; target = 16'h0100; id_ready = 1'b1;
      #1;
      chk("bh_squash", {15'b0, squash}, 16'd1);
      step();
      branch = 1'b0;
      chk("bh_valid", {15'b0, if_valid}, 16'd0);
      chk("bh_squash_off", {15'b0, squash}, 16'd0);
      chk("bh_req", {15'b0, imem_req}, 16'd1);
      chk("bh_addr", imem_addr, 16'h0100);

      // Branch in REQ without grant, then with grant
      branch = 1'b1; target = 16'h0200;
      step();
      branch = 1'b0;
      chk("br_req", {15'b0, imem_req}, 16'd1);
      chk("br_addr", imem_addr, 16'h0200);
      imem_gnt = 1'b1; branch = 1'b1; target = 16'h0300;
      step();
      imem_gnt = 1'b0; branch = 1'b0;
      chk("brg_req", {15'b0, imem_req}, 16'd0);
      imem_rvalid = 1'b1; imem_rdata = 16'hBAD0;
      step();
      imem_rvalid = 1'b0;
      chk("brg_valid", {15'b0, if_valid}, 16'd0);
      chk("brg_req2", {15'b0, imem_req}, 16'd1);
      chk("brg_addr", imem_addr, 16'h0300);

      // Reset while a request is outstanding
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      reset_n = 1'b0;
      step();
      step();
      chk("rw_req", {15'b0, imem_req}, 16'd0);
      chk("rw_addr", imem_addr, 16'h0000);
      reset_n = 1'b1;
      imem_rvalid = 1'b1; imem_rdata = 16'hBEEF;
      step();
      imem_rvalid = 1'b0;
      chk("rw_req2", {15'b0, imem_req}, 16'd1);
      chk("rw_addr2", imem_addr, 16'h0000);
      step();
      chk("rw_valid", {15'b0, if_valid}, 16'd0);
      chk("rw_hold_addr", imem_addr, 16'h0000);

      // PC wrap from 0xFFFF
      chk("wp_req", {15'b0, wp_req}, 16'd1);
      chk("wp_addr0", wp_addr, 16'hFFFF);
      wp_gnt = 1'b1;
      step();
      wp_gnt = 1'b0;
      wp_rvalid = 1'b1; wp_rdata = 16'h7777;
      step();
      wp_rvalid = 1'b0;
      chk("wp_valid", {15'b0, wp_valid}, 16'd1);
      chk("wp_pc", wp_pc, 16'hFFFF);
      chk("wp_instr", wp_instr, 16'h7777);
      wp_ready = 1'b1;
      step();
      chk("wp_req2", {15'b0, wp_req}, 16'd1);
      chk("wp_addr_wrap", wp_addr, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
